multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM that sequences the multicycle MIPS datapath: drives all mux selects (IorD, ALUSrcA/B,
//  MemtoReg, RegDst, PCSource) and write strobes (PC, IR, regfile, memory) per instruction phase.
//  Sits beside the datapath; consumes opcode from IR, ALU zero flag and memory ready; stalls on memory.
// PARAMETERS
//  OP_RTYPE  6'h00  R-type opcode        | OP_LW   6'h23  load word     | OP_SW  6'h2B  store word
//  OP_BEQ    6'h04  branch-equal opcode  | OP_J    6'h02  jump          | OP_ADDI 6'h08 add immediate
// PORTS
//  clk           in   1  rising-edge clock
//  reset         in   1  synchronous, active-high reset
//  opcode        in   6  IR[31:26], valid from DECODE onward
//  zero          in   1  ALU zero flag (used in BRANCH)
//  mem_ready     in   1  memory access complete this cycle
//  pc_write      out  1  unconditional PC load
//  pc_write_cond out  1  PC load if zero
//  i_or_d        out  1  mem addr mux: 0=PC, 1=ALUOut
//  mem_read      out  1  memory read request
//  mem_write     out  1  memory write request
//  ir_write      out  1  IR load
//  mem_to_reg    out  1  regfile data mux: 0=ALUOut, 1=MDR
//  reg_dst       out  1  regfile addr mux: 0=rt, 1=rd
//  reg_write     out  1  regfile write enable
//  alu_src_a     out  1  0=PC, 1=A
//  alu_src_b     out  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
//  alu_op        out  2  0=add, 1=sub, 2=funct-decoded
//  pc_source     out  2  0=ALU result, 1=ALUOut, 2=jump target
//  instr_done    out  1  1-cycle pulse on final cycle of each instruction
//  illegal_op    out  1  1-cycle pulse in DECODE on unknown opcode
//  state         out  4  current state (debug)
// BEHAVIOUR
//  States: FETCH(0) DECODE(1) MEM_ADDR(2) MEM_RD(3) MEM_WB(4) MEM_WR(5) EXEC(6) R_WB(7)
//          BRANCH(8) JUMP(9) ADDI_EX(10) ADDI_WB(11); codes 12-15 unused -> FETCH next cycle.
//  Reset: while reset=1 every strobe (pc_write, pc_write_cond, mem_read, mem_write, ir_write,
//   reg_write, instr_done, illegal_op) forced 0; state<=FETCH at edge. Select outputs 0 except per FETCH.
//  Reset mid-instruction abandons it: no further writes, restart at FETCH.
//  Outputs are combinational decode of state (plus mem_ready/opcode gating noted); all unlisted = 0.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0; ir_write and
//   pc_write asserted only when mem_ready=1; stay in FETCH while mem_ready=0, else -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=3, alu_op=0. Next: LW/SW->MEM_ADDR, RTYPE->EXEC, BEQ->BRANCH,
//   J->JUMP, ADDI->ADDI_EX, other -> FETCH with illegal_op=1 and instr_done=1.
//  MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0 -> LW:MEM_RD, SW:MEM_WR.
//  MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready -> MEM_WB.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
//  MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready; instr_done=mem_ready -> FETCH.
//  EXEC: alu_src_a=1, alu_src_b=0, alu_op=2 -> R_WB.  R_WB: reg_write=1, reg_dst=1, instr_done=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, instr_done=1 -> FETCH.
//  JUMP: pc_write=1, pc_source=2, instr_done=1 -> FETCH.
//  ADDI_EX: alu_src_a=1, alu_src_b=2, alu_op=0 -> ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, instr_done=1 -> FETCH.
//  Latency with mem_ready=1 always: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2 cycles.
//  Each wait cycle with mem_ready=0 adds exactly 1 cycle; mem_read/mem_write held high throughout.
//  Never: mem_read & mem_write together; reg_write & pc_write together; two strobes to same target.
// TESTING
//  T1 reset=1 3 cycles, mem_ready=1 -> all strobes 0, state=0; release -> ir_write,pc_write=1 in cycle 1.
//  T2 opcode=6'h23, mem_ready=1 -> states 0,1,2,3,4; reg_write&mem_to_reg in 5th cycle; instr_done once.
//  T3 opcode=6'h2B, mem_ready low 3 cycles in MEM_WR -> mem_write high 4 cycles, instr_done on 4th only.
//  T4 opcode=6'h04 zero=1 -> BRANCH cycle: pc_write_cond=1, pc_source=1, alu_op=1; total 3 cycles.
//  T5 opcode=6'h3F -> illegal_op=1 in DECODE, next state FETCH, no reg_write/mem_write ever.
//  T6 R-type, assert reset in EXEC -> R_WB skipped, reg_write never 1, state=FETCH after edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM that steers the datapath muxes
// and raises the PC/IR/regfile/memory write strobes for each instruction phase.
// Memory phases stall on mem_ready; reset forces every strobe low at once.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  state_t state_q, state_d;

  // zero is consumed by the datapath through pc_write_cond; the FSM itself
  // never branches on it, so it is only folded into a dummy reduction here.
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  // State register; reset (even mid-instruction) restarts at FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode; strobes are gated off during reset.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle the expected output
// vector is queued when inputs are driven and compared at the falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  localparam int W = 22;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector, field order matches exp_vec below.
  logic [W-1:0] obs;
  assign obs = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};

  // Expected outputs for a given state, taken from the per-state output table.
  function automatic logic [W-1:0] exp_vec(input int st, input logic mr,
                                           input logic [5:0] op, input logic rst);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill;
    logic [1:0] sb, aop, psrc;
    logic legal;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill} = '0;
    sb = 2'd0; aop = 2'd0; psrc = 2'd0;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
            (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
    case (st)
      0:  begin mrd = 1; sb = 2'd1; irw = mr; pw = mr; end
      1:  begin sb = 2'd3; ill = !legal; done = !legal; end
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; iod = 1; done = mr; end
      6:  begin sa = 1; aop = 2'd2; end
      7:  begin rw = 1; rdst = 1; done = 1; end
      8:  begin sa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; done = 1; end
      9:  begin pw = 1; psrc = 2'd2; done = 1; end
      10: begin sa = 1; sb = 2'd2; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    if (rst) {pw, pwc, mrd, mwr, irw, rw, done, ill} = '0;
    return {st[3:0], pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc, done, ill};
  endfunction

  // One clock cycle: drive mem_ready, queue the expectation, check at negedge.
  task automatic step(input string tag, input logic mr, input int exp_state);
    logic [W-1:0] e;
    mem_ready = mr;
    exp_q.push_back(exp_vec(exp_state, mr, opcode, reset));
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h (state obs %0d exp %0d)",
                tag, obs, e, obs[W-1 -: 4], e[W-1 -: 4]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
    @(posedge clk);
    #1;
    // T1: reset held three cycles, then the first fetch.
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 0);
    reset = 1'b0;
    step("t1_fetch", 1'b1, 0);

    // T2: load word, no stalls.
    opcode = 6'h23;
    step("lw_decode", 1'b1, 1);
    step("lw_addr",   1'b1, 2);
    step("lw_rd",     1'b1, 3);
    step("lw_wb",     1'b1, 4);

    // T3: store word with three wait cycles in MEM_WR (and a fetch stall).
    step("sw_fetch_wait", 1'b0, 0);
    opcode = 6'h2B;
    step("sw_fetch",  1'b1, 0);
    step("sw_decode", 1'b1, 1);
    step("sw_addr",   1'b1, 2);
    for (int i = 0; i < 3; i++) step("sw_wr_wait", 1'b0, 5);
    step("sw_wr_done", 1'b1, 5);

    // Load word with a random number of read wait cycles.
    opcode = 6'h23;
    step("lw2_fetch",  1'b1, 0);
    step("lw2_decode", 1'b1, 1);
    step("lw2_addr",   1'b1, 2);
    begin
      int waits;
      waits = $urandom_range(1, 4);
      for (int i = 0; i < waits; i++) step("lw2_rd_wait", 1'b0, 3);
    end
    step("lw2_rd", 1'b1, 3);
    step("lw2_wb", 1'b1, 4);

    // T4: branch-equal with zero set.
    opcode = 6'h04; zero = 1'b1;
    step("beq_fetch",  1'b1, 0);
    step("beq_decode", 1'b1, 1);
    step("beq_branch", 1'b1, 8);
    zero = 1'b0;

    // Jump.
    opcode = 6'h02;
    step("j_fetch",  1'b1, 0);
    step("j_decode", 1'b1, 1);
    step("j_jump",   1'b1, 9);

    // Add immediate.
    opcode = 6'h08;
    step("addi_fetch",  1'b1, 0);
    step("addi_decode", 1'b1, 1);
    step("addi_ex",     1'b1, 10);
    step("addi_wb",     1'b1, 11);

    // T5: illegal opcode.
    opcode = 6'h3F;
    step("ill_fetch",  1'b1, 0);
    step("ill_decode", 1'b1, 1);

    // T6: R-type abandoned by reset in EXEC.
    opcode = 6'h00;
    step("r_fetch",  1'b1, 0);
    step("r_decode", 1'b1, 1);
    reset = 1'b1;
    step("r_exec_reset", 1'b1, 6);
    step("r_after_reset", 1'b1, 0);
    reset = 1'b0;

    // Complete R-type afterwards.
    step("r2_fetch",  1'b1, 0);
    step("r2_decode", 1'b1, 1);
    step("r2_exec",   1'b1, 6);
    step("r2_wb",     1'b1, 7);
    step("r2_next",   1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected finish before bound");
    $fatal(1);
  end

endmodule
